// File: rtl/async_handshake_tx_pkg.sv
// Shared definitions for the pad-side 4-phase transmitter: state encoding,
// synchronizer depth default and timeout counter sizing.
package async_handshake_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        REQ_HI = 2'd2,
        REQ_LO = 2'd3
    } state_t;

    localparam int DEFAULT_SYNC_STAGES    = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    function automatic int tmo_cnt_w(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

    localparam int TMO_CNT_W = tmo_cnt_w(DEFAULT_TIMEOUT_CYCLES);

endpackage

// File: rtl/async_handshake_tx_sync_chain.sv
// N-deep single-bit synchronizer with active-low asynchronous clear, meant
// for any asynchronous level arriving at the pad boundary.
module async_handshake_tx_sync_chain
    import async_handshake_tx_pkg::*;
#(
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/async_handshake_tx.sv
// Clock-domain word -> off-chip 4-phase req/ack transmitter.
// Optional watchdog on the handshake waits: ASYNC_HANDSHAKE_TX_TIMEOUT_EN.
module async_handshake_tx
    import async_handshake_tx_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int SETUP_CYCLES   = 1,
    parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_req,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ack,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        dbg_state
);

    // Producer side: a word moves when in_valid && in_ready at a rising edge;
    // in_ready is held low from that edge until the done edge, and the
    // producer keeps in_valid/in_data stable until it sees in_ready.
    localparam int SETUP_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

    state_t              r_state, w_state_nxt;
    logic [SETUP_W-1:0]  r_setup_cnt, w_setup_nxt;
    logic                r_tx_req, w_req_nxt;
    logic [DATA_W-1:0]   r_tx_data, w_data_nxt;
    logic                r_in_ready, w_ready_nxt;
    logic                r_done, w_done_nxt;
    logic                w_ack_s;

`ifdef ASYNC_HANDSHAKE_TX_TIMEOUT_EN
    localparam int             TMO_W    = tmo_cnt_w(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_tmo_cnt, w_tmo_nxt;
    logic             r_abort, w_abort_nxt;
    logic             r_error, w_err_nxt;
    logic             w_tmo_expired;

    assign w_tmo_expired = (r_tmo_cnt == TMO_LAST);
`endif

    async_handshake_tx_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_d     (tx_ack),
        .o_q     (w_ack_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_setup_cnt <= '0;
            r_tx_req    <= 1'b0;
            r_tx_data   <= '0;
            r_in_ready  <= 1'b0;
            r_done      <= 1'b0;
`ifdef ASYNC_HANDSHAKE_TX_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_abort     <= 1'b0;
            r_error     <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_setup_cnt <= w_setup_nxt;
            r_tx_req    <= w_req_nxt;
            r_tx_data   <= w_data_nxt;
            r_in_ready  <= w_ready_nxt;
            r_done      <= w_done_nxt;
`ifdef ASYNC_HANDSHAKE_TX_TIMEOUT_EN
            r_tmo_cnt   <= w_tmo_nxt;
            r_abort     <= w_abort_nxt;
            r_error     <= w_err_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_setup_nxt = r_setup_cnt;
        w_req_nxt   = r_tx_req;
        w_data_nxt  = r_tx_data;
        w_ready_nxt = r_in_ready;
        w_done_nxt  = 1'b0;
`ifdef ASYNC_HANDSHAKE_TX_TIMEOUT_EN
        w_tmo_nxt   = '0;
        w_abort_nxt = r_abort;
        w_err_nxt   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_ready_nxt = 1'b1;
                if (in_valid && r_in_ready) begin
                    w_data_nxt  = in_data;
                    w_ready_nxt = 1'b0;
                    w_setup_nxt = SETUP_W'(SETUP_CYCLES - 1);
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                // A stale ack from the previous word holds off the new request.
                if (r_setup_cnt != '0) begin
                    w_setup_nxt = r_setup_cnt - 1'b1;
                end else if (!w_ack_s) begin
                    w_req_nxt   = 1'b1;
                    w_state_nxt = REQ_HI;
                end
            end
            REQ_HI: begin
`ifdef ASYNC_HANDSHAKE_TX_TIMEOUT_EN
                w_tmo_nxt = r_tmo_cnt + 1'b1;
`endif
                if (w_ack_s) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = REQ_LO;
`ifdef ASYNC_HANDSHAKE_TX_TIMEOUT_EN
                    w_tmo_nxt   = '0;
                end else if (w_tmo_expired) begin
                    w_req_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_abort_nxt = 1'b1;
                    w_state_nxt = REQ_LO;
                    w_tmo_nxt   = '0;
`endif
                end
            end
            REQ_LO: begin
`ifdef ASYNC_HANDSHAKE_TX_TIMEOUT_EN
                w_tmo_nxt = r_tmo_cnt + 1'b1;
`endif
                if (!w_ack_s) begin
                    // A word whose request timed out is dropped, not completed.
`ifdef ASYNC_HANDSHAKE_TX_TIMEOUT_EN
                    w_done_nxt  = !r_abort;
                    w_abort_nxt = 1'b0;
                    w_tmo_nxt   = '0;
`else
                    w_done_nxt  = 1'b1;
`endif
                    w_ready_nxt = 1'b1;
                    w_state_nxt = IDLE;
`ifdef ASYNC_HANDSHAKE_TX_TIMEOUT_EN
                end else if (w_tmo_expired) begin
                    w_err_nxt   = 1'b1;
                    w_abort_nxt = 1'b0;
                    w_ready_nxt = 1'b1;
                    w_state_nxt = IDLE;
                    w_tmo_nxt   = '0;
`endif
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign in_ready  = r_in_ready;
    assign tx_req    = r_tx_req;
    assign tx_data   = r_tx_data;
    assign done      = r_done;
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

`ifdef ASYNC_HANDSHAKE_TX_TIMEOUT_EN
    assign error = r_error;
`else
    // No watchdog: TIMEOUT_CYCLES is non-negative, so this is constant 0.
    assign error = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_async_handshake_tx.sv
// Bench for async_handshake_tx: two instances (default timing and a slower
// SETUP/SYNC/TIMEOUT set) driven by a delayed-echo receiver model.
module tb_async_handshake_tx;
  import async_handshake_tx_pkg::*;

  localparam int S_A = 1;
  localparam int Y_A = 2;
  localparam int S_B = 4;
  localparam int Y_B = 3;
  localparam int T_B = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       in_valid [2];
  logic [7:0] in_data [2];
  logic       in_ready [2];
  logic       tx_req [2];
  logic [7:0] tx_data [2];
  logic       tx_ack [2];
  logic       busy [2];
  logic       done [2];
  logic       error [2];
  logic [1:0] dbg_state [2];

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  logic [7:0] exp_q[$];

  // receiver model controls
  logic force_en [2] = '{1'b1, 1'b1};
  logic force_val [2] = '{1'b0, 1'b0};
  int   rx_delay [2] = '{0, 0};
  logic req_hist [2][16];

  async_handshake_tx #(.DATA_W(8), .SETUP_CYCLES(S_A), .SYNC_STAGES(Y_A)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .tx_req(tx_req[0]), .tx_data(tx_data[0]), .tx_ack(tx_ack[0]),
    .busy(busy[0]), .done(done[0]), .error(error[0]), .dbg_state(dbg_state[0])
  );

  async_handshake_tx #(.DATA_W(8), .SETUP_CYCLES(S_B), .SYNC_STAGES(Y_B), .TIMEOUT_CYCLES(T_B)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .tx_req(tx_req[1]), .tx_data(tx_data[1]), .tx_ack(tx_ack[1]),
    .busy(busy[1]), .done(done[1]), .error(error[1]), .dbg_state(dbg_state[1])
  );

  // Receiver: tx_ack follows tx_req sampled rx_delay falling edges earlier.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 15; k > 0; k--) req_hist[i][k] = req_hist[i][k-1];
      req_hist[i][0] = tx_req[i];
      tx_ack[i] = force_en[i] ? force_val[i] : req_hist[i][rx_delay[i]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int s_of(input int i);
    return (i == 0) ? S_A : S_B;
  endfunction

  function automatic int y_of(input int i);
    return (i == 0) ? Y_A : Y_B;
  endfunction

  // One full transfer with the echo receiver at delay d. Expected edge
  // numbers (relative to the capture edge) follow from the handshake rules:
  // req rises after S edges; each ack change takes d (receiver) + Y (sync)
  // + 1 (registered reaction) edges to be answered.
  task automatic send(input int i, input logic [7:0] w, input int d,
                      input logic hold, input logic [7:0] hold_w);
    int n, cap, rise, fall, dn;
    logic data_ok, ready_ok;
    logic [7:0] exp_w;
    rx_delay[i] = d;
    n = 0;
    while (in_ready[i] !== 1'b1 && n < 100) begin tick(); n++; end
    chk("ready_before_send", in_ready[i], 1);
    in_valid[i] = 1'b1;
    in_data[i] = w;
    exp_q.push_back(w);
    tick();
    cap = edge_n;
    chk("accept_ready_low", in_ready[i], 0);
    chk("accept_tx_data", tx_data[i], w);
    chk("accept_busy", busy[i], 1);
    chk("accept_no_done", done[i], 0);
    if (hold) in_data[i] = hold_w;
    else in_valid[i] = 1'b0;
    rise = -1; fall = -1; dn = -1;
    data_ok = 1'b1; ready_ok = 1'b1;
    for (int k = 0; k < 200 && dn < 0; k++) begin
      tick();
      n = edge_n - cap;
      if (tx_data[i] !== w) data_ok = 1'b0;
      if (rise < 0 && tx_req[i] === 1'b1) rise = n;
      if (rise >= 0 && fall < 0 && tx_req[i] === 1'b0) fall = n;
      if (done[i] === 1'b1) dn = n;
      else if (in_ready[i] !== 1'b0) ready_ok = 1'b0;
    end
    chk("req_rise_edge", rise, s_of(i));
    chk("req_fall_edge", fall, s_of(i) + d + y_of(i) + 1);
    chk("done_edge", dn, s_of(i) + 2 * (d + y_of(i) + 1));
    chk("data_stable", data_ok, 1);
    chk("ready_low_busy", ready_ok, 1);
    chk("done_no_error", error[i], 0);
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    chk("sb_word", tx_data[i], exp_w);
  endtask

  initial begin
    int k0, n, rise, err_n, err_cnt, done_cnt;
    logic req_at_err;
    logic ok;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      in_data[i] = 8'h00;
    end

    // reset state
    #1;
    chk("rst_tx_req", tx_req[0], 0);
    chk("rst_tx_data", tx_data[0], 0);
    chk("rst_in_ready", in_ready[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_error", error[0], 0);
    tick(); tick(); tick();
    reset_n = 1'b1;
    chk("rel_ready_before_edge", in_ready[0], 0);
    tick();
    chk("rel_ready_first_edge_a", in_ready[0], 1);
    chk("rel_ready_first_edge_b", in_ready[1], 1);
    for (int k = 0; k < 18; k++) tick();
    force_en[0] = 1'b0;
    force_en[1] = 1'b0;
    tick();

    // single transfer, receiver echoes after 3 cycles
    send(0, 8'hA5, 3, 1'b0, 8'h00);
    chk("single_done_once", done[0], 1);
    tick();
    chk("single_done_pulse_end", done[0], 0);
    chk("single_data_held", tx_data[0], 8'hA5);

    // back-to-back with in_valid held high through busy periods
    for (int k = 0; k < 6; k++) tick();
    send(0, 8'h01, 1, 1'b1, 8'h02);
    send(0, 8'h02, 1, 1'b1, 8'h03);
    send(0, 8'h03, 1, 1'b0, 8'h00);

    // stale ack held high at accept time
    for (int k = 0; k < 6; k++) tick();
    force_val[0] = 1'b1;
    force_en[0] = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    in_valid[0] = 1'b1;
    in_data[0] = 8'h5A;
    exp_q.push_back(8'h5A);
    tick();
    in_valid[0] = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (tx_req[0] !== 1'b0 || dbg_state[0] !== SETUP) ok = 1'b0;
    end
    chk("stale_ack_hold_setup", ok, 1);
    rx_delay[0] = 0;
    force_en[0] = 1'b0;
    k0 = edge_n;
    rise = -1;
    done_cnt = -1;
    for (int k = 0; k < 60 && done_cnt < 0; k++) begin
      tick();
      if (rise < 0 && tx_req[0] === 1'b1) rise = edge_n - k0;
      if (done[0] === 1'b1) done_cnt = edge_n - k0;
    end
    chk("stale_ack_rise_edge", rise, Y_A + 1);
    chk("stale_ack_done_edge", done_cnt, Y_A + 1 + 2 * (Y_A + 1));
    chk("stale_ack_sb_word", tx_data[0], exp_q.pop_front());

    // randomized transfers on the default instance
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 6; k++) tick();
      send(0, 8'($urandom_range(0, 255)), int'($urandom_range(0, 4)), 1'b0, 8'h00);
    end

    // slower instance: SETUP_CYCLES=4, SYNC_STAGES=3
    send(1, 8'hC3, 0, 1'b0, 8'h00);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 6; k++) tick();
      send(1, 8'($urandom_range(0, 255)), int'($urandom_range(0, 4)), 1'b0, 8'h00);
    end

    // ack stuck low on the slower instance
    for (int k = 0; k < 6; k++) tick();
    force_val[1] = 1'b0;
    force_en[1] = 1'b1;
    tick();
    in_valid[1] = 1'b1;
    in_data[1] = 8'h77;
    tick();
    in_valid[1] = 1'b0;
    n = 0;
    while (tx_req[1] !== 1'b1 && n < 50) begin tick(); n++; end
    chk("stuck_req_rises", tx_req[1], 1);
    err_n = -1; err_cnt = 0; done_cnt = 0; req_at_err = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (error[1] === 1'b1) begin
        err_cnt++;
        if (err_n < 0) begin err_n = k; req_at_err = tx_req[1]; end
      end
      if (done[1] === 1'b1) done_cnt++;
    end
    chk("stuck_no_done", done_cnt, 0);
`ifdef ASYNC_HANDSHAKE_TX_TIMEOUT_EN
    chk("tmo_error_edge", err_n, T_B);
    chk("tmo_error_pulses", err_cnt, 1);
    chk("tmo_req_dropped", req_at_err, 0);
    chk("tmo_back_to_idle", in_ready[1], 1);
    chk("tmo_not_busy", busy[1], 0);
`else
    chk("notmo_no_error", err_cnt, 0);
    chk("notmo_req_held", tx_req[1], 1);
    chk("notmo_still_busy", busy[1], 1);
    rx_delay[1] = 0;
    force_en[1] = 1'b0;
    n = 0;
    while (done[1] !== 1'b1 && n < 100) begin tick(); n++; end
    chk("notmo_late_done", done[1], 1);
    chk("notmo_late_word", tx_data[1], 8'h77);
`endif

    // reset in the middle of REQ_HI
    for (int k = 0; k < 6; k++) tick();
    force_val[0] = 1'b0;
    force_en[0] = 1'b1;
    tick();
    in_valid[0] = 1'b1;
    in_data[0] = 8'h3C;
    tick();
    in_valid[0] = 1'b0;
    n = 0;
    while (tx_req[0] !== 1'b1 && n < 50) begin tick(); n++; end
    tick(); tick();
    chk("midrst_in_req_hi", dbg_state[0], REQ_HI);
    chk("midrst_data_before", tx_data[0], 8'h3C);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_req_async", tx_req[0], 0);
    chk("midrst_data_async", tx_data[0], 0);
    chk("midrst_ready", in_ready[0], 0);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_done", done[0], 0);
    tick(); tick();
    reset_n = 1'b1;
    chk("midrst_ready_before_edge", in_ready[0], 0);
    tick();
    chk("midrst_ready_first_edge", in_ready[0], 1);
    chk("midrst_no_done", done[0], 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
